id_ex: RTL
==========

// Module: id_ex
// PURPOSE
// - ID->EX pipeline register. It captures the decoder's ALU op, ALU select, operands,
//   destination register and write-enable at each clock edge, and presents them to the
//   execute stage.
// - It supports three actions, driven by the pipeline control unit:
//   - hold on stall;
//   - bubble insertion on a decode-only stall;
//   - flush.
// - It also carries an issue-valid flag and a count of instructions issued to EX.
// PARAMETERS
// - DATA_W  32  operand width (reg1/reg2). Equals RegBus.
// - CNT_W   16  width of the issued-instruction counter.
// PORTS
// - Clk           in   1       system clock. All state updates on its rising edge.
// - Rst_n         in   1       synchronous reset, active-high (RstEnable = 1'b1). Sampled on Clk rise only.
// - flush_i       in   1       discard the ID-stage contents and load a bubble.
// - stall_id_i    in   1       ID stage stalled this cycle.
// - stall_ex_i    in   1       EX stage stalled this cycle.
// - id_valid_i    in   1       ID outputs hold a real instruction.
// - id_pc_i       in   32      PC of the instruction in ID.
// - id_aluop_i    in   8       decoded ALU operation (AluOpBus).
// - id_alusel_i   in   3       decoded result select (AluSelBus).
// - id_reg1_i     in   DATA_W  operand 1: register data or immediate.
// - id_reg2_i     in   DATA_W  operand 2: register data or immediate.
// - id_wd_i       in   5       destination register address.
// - id_wreg_i     in   1       destination write enable.
// - ex_valid_o    out  1       EX holds a real instruction.
// - ex_pc_o       out  32      registered PC.
// - ex_aluop_o    out  8       registered ALU op.
// - ex_alusel_o   out  3       registered result select.
// - ex_reg1_o     out  DATA_W  registered operand 1.
// - ex_reg2_o     out  DATA_W  registered operand 2.
// - ex_wd_o       out  5       registered destination address.
// - ex_wreg_o     out  1       registered write enable.
// - issue_cnt_o   out  CNT_W   number of real instructions loaded into EX.
// BEHAVIOUR
// - All outputs are registered. Latency from ID inputs to EX outputs is one Clk cycle.
// - There is no combinational path from any input to any output.
// - "Bubble" means:
//   - aluop = EXE_NOP_OP (8'h00), alusel = EXE_RES_NOP (3'b000);
//   - reg1 = 0, reg2 = 0, wd = NOPRegAddr (5'h0), wreg = WriteDisable (0);
//   - valid = 0, pc = 0.
// - Per-edge action, in strict priority order:
//   1. Rst_n = 1: all outputs become the bubble values, and issue_cnt_o = 0.
//   2. flush_i = 1: load a bubble. This applies even if stall_ex_i = 1, because flush beats stall.
//   3. stall_ex_i = 1: hold every output, whatever stall_id_i is.
//   4. stall_id_i = 1 (and stall_ex_i = 0): load a bubble, so EX advances while ID waits.
//   5. Otherwise: load all id_* inputs. ex_valid_o <= id_valid_i.
// - Counter:
//   - issue_cnt_o increments by 1 only on a case-5 load with id_valid_i = 1.
//   - It is unchanged by holds, bubbles and flushes.
//   - It wraps from 2^CNT_W-1 to 0 silently.
// - No field is qualified by id_valid_i. On a case-5 load with id_valid_i = 0, every field
//   is copied as presented, and downstream logic must use ex_valid_o.
// - stall_ex_i = 1 with stall_id_i = 0 is illegal from the control unit.
//   - The block still applies rule 3 (hold).
//   - The bench must flag it with an assertion.
// - Reset mid-stall or mid-flush: reset wins. The next edge after reset deasserts follows
//   normal priority.
// - No X may propagate from the outputs after the first reset edge, even if the inputs are X
//   while stalled or flushed.
// TESTING
// - Reset: hold Rst_n=1 for 2 edges with random inputs -> all outputs are bubble values and
//   issue_cnt_o=0.
// - Pass-through: ORI, aluop=8'h25, alusel=3'b001, reg1=32'h1234, reg2=32'h0000_ABCD, wd=5'd3,
//   wreg=1, valid=1 -> the same values appear one edge later, and issue_cnt_o goes 0->1.
// - Decode stall: stall_id_i=1, stall_ex_i=0 for 3 edges -> three bubbles (ex_wreg_o=0,
//   ex_valid_o=0) and the count is unchanged. On release, the held ID instruction is loaded.
// - EX stall: stall_ex_i=stall_id_i=1 for 4 edges with ID inputs changing -> EX outputs are
//   frozen at their prior values, and the count is unchanged.
// - Flush during EX stall: flush_i=1, stall_ex_i=1 -> bubble loaded on that edge, and the count
//   is unchanged.
// - Wrap: CNT_W=4, 17 consecutive valid loads -> issue_cnt_o ends at 1. Reset asserted
//   mid-sequence -> count 0 on the next edge.

Source files
------------

// File: rtl/id_ex.sv
// ID->EX pipeline register: captures decoded fields each edge, with stall hold,
// decode-only bubble insertion, flush, an issue-valid flag and an issued-instruction counter.
module id_ex #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              flush_i,
    input  logic              stall_id_i,
    input  logic              stall_ex_i,
    input  logic              id_valid_i,
    input  logic [31:0]       id_pc_i,
    input  logic [7:0]        id_aluop_i,
    input  logic [2:0]        id_alusel_i,
    input  logic [DATA_W-1:0] id_reg1_i,
    input  logic [DATA_W-1:0] id_reg2_i,
    input  logic [4:0]        id_wd_i,
    input  logic              id_wreg_i,
    output logic              ex_valid_o,
    output logic [31:0]       ex_pc_o,
    output logic [7:0]        ex_aluop_o,
    output logic [2:0]        ex_alusel_o,
    output logic [DATA_W-1:0] ex_reg1_o,
    output logic [DATA_W-1:0] ex_reg2_o,
    output logic [4:0]        ex_wd_o,
    output logic              ex_wreg_o,
    output logic [CNT_W-1:0]  issue_cnt_o
);

    typedef struct packed {
        logic [31:0]              pc;
        logic [7:0]               aluop;
        logic [2:0]               alusel;
        logic signed [DATA_W-1:0] reg1;
        logic signed [DATA_W-1:0] reg2;
        logic [4:0]               wd;
        logic                     wreg;
    } ex_fields_t;

    ex_fields_t       id_p0;
    ex_fields_t       ex_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] issue_cnt_p1;

    // A bubble is all-zero: NOP op, NOP select, zero operands, r0 target, write disabled.
    function automatic ex_fields_t bubble();
        return '0;
    endfunction

    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

    assign id_p0 = {id_pc_i, id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_wd_i, id_wreg_i};

    // ---- ID -> EX boundary ----
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            ex_p1        <= bubble();
            vld_p1       <= 1'b0;
            issue_cnt_p1 <= '0;
        end else if (flush_i) begin
            ex_p1  <= bubble();
            vld_p1 <= 1'b0;
        end else if (!stall_ex_i) begin
            if (stall_id_i) begin
                ex_p1  <= bubble();
                vld_p1 <= 1'b0;
            end else begin
                ex_p1  <= id_p0;
                vld_p1 <= id_valid_i;
                if (id_valid_i) begin
                    issue_cnt_p1 <= wrap_inc(issue_cnt_p1);
                end
            end
        end
    end

    assign ex_valid_o  = vld_p1;
    assign ex_pc_o     = ex_p1.pc;
    assign ex_aluop_o  = ex_p1.aluop;
    assign ex_alusel_o = ex_p1.alusel;
    assign ex_reg1_o   = ex_p1.reg1;
    assign ex_reg2_o   = ex_p1.reg2;
    assign ex_wd_o     = ex_p1.wd;
    assign ex_wreg_o   = ex_p1.wreg;
    assign issue_cnt_o = issue_cnt_p1;

endmodule
